// File: rtl/multi_pwm_if.sv
// Control/status bundle for the multi-channel PWM block.
// Master side (software/bus glue) drives run control and parameters,
// slave side (the PWM core) returns the outputs and the counter value.
interface multi_pwm_if #(
    parameter int DATA_WIDTH = 16,
    parameter int NCH        = 4
);
    logic                      i_en;
    logic                      i_mode;
    logic [DATA_WIDTH-1:0]     i_ovf;
    logic [NCH*DATA_WIDTH-1:0] i_dc;
    logic [NCH-1:0]            i_pol;
    logic                      i_upd;
    logic [NCH-1:0]            o_pwm;
    logic                      o_period;
    logic [DATA_WIDTH-1:0]     o_cnt;

    modport master (
        output i_en, i_mode, i_ovf, i_dc, i_pol, i_upd,
        input  o_pwm, o_period, o_cnt
    );

    modport slave (
        input  i_en, i_mode, i_ovf, i_dc, i_pol, i_upd,
        output o_pwm, o_period, o_cnt
    );
endinterface

// File: rtl/multi_pwm.sv
// NCH-channel PWM generator sharing one period counter.
// Edge- or centre-aligned counting, per-channel polarity, and a shadow
// register set that only becomes active on a period boundary (or while
// stopped) so parameter updates never produce a truncated pulse.
module multi_pwm #(
    parameter int DATA_WIDTH = 16,
    parameter int NCH        = 4
) (
    input  logic      i_clk,
    input  logic      i_rst_n,
    multi_pwm_if.slave bus
);
    typedef logic [DATA_WIDTH-1:0] cnt_t;

    // shadow and active parameter sets
    logic                            r_sh_mode, r_act_mode;
    cnt_t                            r_sh_ovf, r_act_ovf;
    logic [NCH-1:0][DATA_WIDTH-1:0]  r_sh_dc, r_act_dc;
    logic [NCH-1:0]                  r_sh_pol, r_act_pol;
    logic                            r_pend;

    // counter state
    cnt_t           r_cnt;
    logic           r_dir_up;
    logic           r_pe;       // r_cnt currently holds the first count of a period
    logic [NCH-1:0] r_pwm;
    logic           r_period;

    cnt_t           w_cnt_nxt;
    logic           w_dir_nxt;
    logic           w_edge;
    logic           w_period_end;
    logic           w_load;
    logic [NCH-1:0] w_raw;

    // next count; centre mode with ovf=0 degenerates to edge counting
    always_comb begin
        w_edge    = ~r_act_mode | (r_act_ovf == '0);
        w_cnt_nxt = '0;
        w_dir_nxt = 1'b1;
        if (w_edge || (r_cnt > r_act_ovf)) begin
            // also catches an out-of-range count in centre mode
            w_cnt_nxt = (r_cnt >= r_act_ovf) ? '0 : r_cnt + cnt_t'(1);
        end else if (r_dir_up) begin
            if (r_cnt == r_act_ovf) begin
                w_cnt_nxt = r_cnt - cnt_t'(1);
                w_dir_nxt = 1'b0;
            end else begin
                w_cnt_nxt = r_cnt + cnt_t'(1);
            end
        end else begin
            w_cnt_nxt = (r_cnt == '0) ? '0 : r_cnt - cnt_t'(1);
            w_dir_nxt = 1'b0;
        end
        // every return to 0 starts a new period counting up
        if (w_cnt_nxt == '0) begin
            w_dir_nxt = 1'b1;
        end
        w_period_end = bus.i_en & (w_cnt_nxt == '0);
        w_load       = ~bus.i_en | w_period_end;
    end

    // shadow capture and boundary transfer to the active set; a capture on
    // the boundary edge wins over the pend clear so the new values wait a period
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sh_mode  <= 1'b0;
            r_sh_ovf   <= '0;
            r_sh_dc    <= '0;
            r_sh_pol   <= '0;
            r_act_mode <= 1'b0;
            r_act_ovf  <= '0;
            r_act_dc   <= '0;
            r_act_pol  <= '0;
            r_pend     <= 1'b0;
        end else begin
            if (w_load && r_pend) begin
                r_act_mode <= r_sh_mode;
                r_act_ovf  <= r_sh_ovf;
                r_act_dc   <= r_sh_dc;
                r_act_pol  <= r_sh_pol;
                r_pend     <= 1'b0;
            end
            if (bus.i_upd) begin
                r_sh_mode <= bus.i_mode;
                r_sh_ovf  <= bus.i_ovf;
                r_sh_dc   <= bus.i_dc;
                r_sh_pol  <= bus.i_pol;
                r_pend    <= 1'b1;
            end
        end
    end

    // period counter; held at 0 counting up while stopped
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt    <= '0;
            r_dir_up <= 1'b1;
        end else if (!bus.i_en) begin
            r_cnt    <= '0;
            r_dir_up <= 1'b1;
        end else begin
            r_cnt    <= w_cnt_nxt;
            r_dir_up <= w_dir_nxt;
        end
    end

    // per-channel compare against the active duty
    for (genvar k = 0; k < NCH; k++) begin : g_ch
        assign w_raw[k] = (r_cnt < r_act_dc[k]);
    end

    // registered outputs; o_period lines up with the o_pwm sample of count 0
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pwm    <= '0;
            r_period <= 1'b0;
            r_pe     <= 1'b1;
        end else if (!bus.i_en) begin
            r_pwm    <= r_act_pol;
            r_period <= 1'b0;
            r_pe     <= 1'b1;
        end else begin
            r_pwm    <= w_raw ^ r_act_pol;
            r_period <= r_pe;
            r_pe     <= w_period_end;
        end
    end

    assign bus.o_pwm    = r_pwm;
    assign bus.o_period = r_period;
    assign bus.o_cnt    = r_cnt;
endmodule

// File: tb/tb_multi_pwm.sv
// Bench for multi_pwm: a period-position reference model (position p within
// the period, count derived arithmetically) plus directed pulse-width checks.
module tb_multi_pwm;
    localparam int DW  = 16;
    localparam int NCH = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    multi_pwm_if #(.DATA_WIDTH(DW), .NCH(NCH)) bus ();
    multi_pwm #(.DATA_WIDTH(DW), .NCH(NCH)) dut (.i_clk(clk), .i_rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    // reference model state
    int             m_p;
    bit             m_pend;
    bit             a_mode, s_mode;
    int             a_ovf, s_ovf;
    int             a_dc[NCH];
    int             s_dc[NCH];
    bit [NCH-1:0]   a_pol, s_pol;
    logic [NCH-1:0] m_pwm;
    logic           m_period;
    logic [DW-1:0]  m_cnt;

    function automatic int f_per();
        return (a_mode && a_ovf != 0) ? 2 * a_ovf : a_ovf + 1;
    endfunction

    function automatic int f_cnt(input int p);
        if (a_mode && a_ovf != 0 && p > a_ovf) return 2 * a_ovf - p;
        return p;
    endfunction

    task automatic model_reset();
        m_p = 0; m_pend = 0; a_mode = 0; s_mode = 0; a_ovf = 0; s_ovf = 0;
        a_pol = '0; s_pol = '0; m_pwm = '0; m_period = 0; m_cnt = '0;
        for (int k = 0; k < NCH; k++) begin a_dc[k] = 0; s_dc[k] = 0; end
    endtask

    // one clock edge: advance the model with the inputs present at the edge
    task automatic step();
        int c;
        bit pe;
        bit en;
        @(posedge clk);
        en = bus.i_en;
        c  = f_cnt(m_p);
        for (int k = 0; k < NCH; k++)
            m_pwm[k] = en ? ((c < a_dc[k]) ^ a_pol[k]) : a_pol[k];
        m_period = en && (m_p == 0);
        pe = en && (m_p == f_per() - 1);
        m_p = (en && !pe) ? m_p + 1 : 0;
        if ((!en || pe) && m_pend) begin
            a_mode = s_mode; a_ovf = s_ovf; a_pol = s_pol; a_dc = s_dc; m_pend = 0;
        end
        if (bus.i_upd) begin
            s_mode = bus.i_mode; s_ovf = int'(bus.i_ovf); s_pol = bus.i_pol; m_pend = 1;
            for (int k = 0; k < NCH; k++) s_dc[k] = int'(bus.i_dc[k*DW +: DW]);
        end
        m_cnt = DW'(f_cnt(m_p));
        #1;
    endtask

    task automatic set_cfg(input bit mode, input int ovf, input int d0, input int d1,
                           input int d2, input int d3, input bit [NCH-1:0] pol);
        bus.i_mode = mode;
        bus.i_ovf  = DW'(ovf);
        bus.i_dc   = {DW'(d3), DW'(d2), DW'(d1), DW'(d0)};
        bus.i_pol  = pol;
    endtask

    task automatic pulse_upd();
        bus.i_upd = 1'b1;
        step();
        bus.i_upd = 1'b0;
    endtask

    task automatic test_reset();
        bus.i_en = 0; bus.i_upd = 0;
        set_cfg(0, 0, 0, 0, 0, 0, '0);
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        model_reset();
        n_cmp++; if (bus.o_pwm !== '0) begin n_err++; $display("FAIL reset_pwm: got %b want 0", bus.o_pwm); end
        n_cmp++; if (bus.o_period !== 1'b0) begin n_err++; $display("FAIL reset_period: got %b want 0", bus.o_period); end
        n_cmp++; if (bus.o_cnt !== '0) begin n_err++; $display("FAIL reset_cnt: got %0d want 0", bus.o_cnt); end
        rst_n = 1'b1;
    endtask

    task automatic test_edge();
        int hi = 0, per = 0;
        set_cfg(0, 9, 3, 0, 0, 0, '0);
        bus.i_en = 1;
        pulse_upd();
        for (int i = 0; i < 40; i++) begin
            step();
            n_cmp++;
            if (bus.o_pwm !== m_pwm || bus.o_period !== m_period || bus.o_cnt !== m_cnt) begin
                n_err++;
                $display("FAIL edge_model cyc %0d: got pwm=%b per=%b cnt=%0d want pwm=%b per=%b cnt=%0d",
                         i, bus.o_pwm, bus.o_period, bus.o_cnt, m_pwm, m_period, m_cnt);
            end
        end
        for (int i = 0; i < 20; i++) begin step(); hi += bus.o_pwm[0]; per += bus.o_period; end
        n_cmp++; if (hi != 6) begin n_err++; $display("FAIL edge_width: got %0d high want 6", hi); end
        n_cmp++; if (per != 2) begin n_err++; $display("FAIL edge_period: got %0d pulses want 2", per); end
    endtask

    task automatic test_centre();
        int exp_seq[8] = '{0, 1, 2, 3, 4, 3, 2, 1};
        int hi = 0;
        set_cfg(1, 4, 2, 0, 0, 0, '0);
        pulse_upd();
        for (int i = 0; i < 24; i++) begin
            step();
            n_cmp++;
            if (bus.o_pwm !== m_pwm || bus.o_period !== m_period || bus.o_cnt !== m_cnt) begin
                n_err++;
                $display("FAIL centre_model cyc %0d: got pwm=%b per=%b cnt=%0d want pwm=%b per=%b cnt=%0d",
                         i, bus.o_pwm, bus.o_period, bus.o_cnt, m_pwm, m_period, m_cnt);
            end
        end
        for (int i = 0; i < 20 && bus.o_cnt != 0; i++) step();
        n_cmp++; if (bus.o_cnt !== '0) begin n_err++; $display("FAIL centre_sync: cnt %0d want 0", bus.o_cnt); end
        for (int i = 0; i < 8; i++) begin
            n_cmp++;
            if (int'(bus.o_cnt) != exp_seq[i]) begin
                n_err++; $display("FAIL centre_seq[%0d]: got %0d want %0d", i, bus.o_cnt, exp_seq[i]);
            end
            step();
            hi += bus.o_pwm[0];
        end
        n_cmp++; if (hi != 3) begin n_err++; $display("FAIL centre_width: got %0d want 3", hi); end
    endtask

    task automatic test_shadow();
        int hi;
        set_cfg(0, 9, 3, 0, 0, 0, '0);
        pulse_upd();
        for (int i = 0; i < 25; i++) begin
            step();
            n_cmp++;
            if (bus.o_pwm !== m_pwm || bus.o_period !== m_period || bus.o_cnt !== m_cnt) begin
                n_err++;
                $display("FAIL shadow_model cyc %0d: got pwm=%b per=%b cnt=%0d want pwm=%b per=%b cnt=%0d",
                         i, bus.o_pwm, bus.o_period, bus.o_cnt, m_pwm, m_period, m_cnt);
            end
        end
        for (int i = 0; i < 20 && bus.o_cnt != 5; i++) step();
        n_cmp++; if (bus.o_cnt !== DW'(5)) begin n_err++; $display("FAIL shadow_wait5: cnt %0d want 5", bus.o_cnt); end
        set_cfg(0, 9, 7, 0, 0, 0, '0);
        pulse_upd();
        for (int i = 0; i < 20 && bus.o_cnt != 9; i++) begin
            n_cmp++;
            if (bus.o_pwm !== m_pwm || bus.o_cnt !== m_cnt) begin
                n_err++; $display("FAIL shadow_keep cyc %0d: got pwm=%b cnt=%0d want pwm=%b cnt=%0d",
                                  i, bus.o_pwm, bus.o_cnt, m_pwm, m_cnt);
            end
            step();
        end
        n_cmp++; if (bus.o_cnt !== DW'(9)) begin n_err++; $display("FAIL shadow_wait9: cnt %0d want 9", bus.o_cnt); end
        // update lands on the boundary edge: 7 runs next period, 5 the one after
        set_cfg(0, 9, 5, 0, 0, 0, '0);
        pulse_upd();
        hi = 0;
        for (int i = 0; i < 10; i++) begin step(); hi += bus.o_pwm[0]; end
        n_cmp++; if (hi != 7) begin n_err++; $display("FAIL shadow_next: got %0d high want 7", hi); end
        hi = 0;
        for (int i = 0; i < 10; i++) begin step(); hi += bus.o_pwm[0]; end
        n_cmp++; if (hi != 5) begin n_err++; $display("FAIL shadow_later: got %0d high want 5", hi); end
    endtask

    task automatic test_limits();
        int tbl_dc[4]  = '{0, 12, 0, 12};
        int tbl_pol[4] = '{0, 0, 1, 1};
        int tbl_hi[4]  = '{0, 20, 20, 0};
        int hi, per;
        for (int t = 0; t < 4; t++) begin
            set_cfg(0, 9, tbl_dc[t], 0, 0, 0, NCH'(tbl_pol[t]));
            pulse_upd();
            for (int i = 0; i < 12; i++) begin
                step();
                n_cmp++;
                if (bus.o_pwm !== m_pwm || bus.o_cnt !== m_cnt) begin
                    n_err++; $display("FAIL limit_model t%0d cyc %0d: got pwm=%b cnt=%0d want pwm=%b cnt=%0d",
                                      t, i, bus.o_pwm, bus.o_cnt, m_pwm, m_cnt);
                end
            end
            hi = 0;
            for (int i = 0; i < 20; i++) begin step(); hi += bus.o_pwm[0]; end
            n_cmp++;
            if (hi != tbl_hi[t]) begin n_err++; $display("FAIL limit_width t%0d: got %0d want %0d", t, hi, tbl_hi[t]); end
        end
        set_cfg(0, 0, 0, 0, 0, 0, '0);
        pulse_upd();
        repeat (12) step();
        per = 0;
        for (int i = 0; i < 10; i++) begin step(); per += bus.o_period; end
        n_cmp++; if (per != 10) begin n_err++; $display("FAIL limit_ovf0: got %0d pulses want 10", per); end
    endtask

    task automatic test_multi();
        int exp_hi[NCH] = '{2, 6, 6, 2};
        int hi[NCH]     = '{0, 0, 0, 0};
        set_cfg(0, 4, 1, 2, 3, 4, 4'b1010);
        pulse_upd();
        for (int i = 0; i < 12; i++) begin
            step();
            n_cmp++;
            if (bus.o_pwm !== m_pwm || bus.o_period !== m_period || bus.o_cnt !== m_cnt) begin
                n_err++;
                $display("FAIL multi_model cyc %0d: got pwm=%b per=%b cnt=%0d want pwm=%b per=%b cnt=%0d",
                         i, bus.o_pwm, bus.o_period, bus.o_cnt, m_pwm, m_period, m_cnt);
            end
        end
        for (int i = 0; i < 10; i++) begin
            step();
            for (int k = 0; k < NCH; k++) hi[k] += bus.o_pwm[k];
        end
        for (int k = 0; k < NCH; k++) begin
            n_cmp++;
            if (hi[k] != exp_hi[k]) begin n_err++; $display("FAIL multi_width ch%0d: got %0d want %0d", k, hi[k], exp_hi[k]); end
        end
    endtask

    task automatic test_enable();
        for (int i = 0; i < 10 && bus.o_cnt != 2; i++) step();
        bus.i_en = 0;
        step();
        n_cmp++; if (bus.o_pwm !== 4'b1010) begin n_err++; $display("FAIL en_pwm: got %b want 1010", bus.o_pwm); end
        n_cmp++; if (bus.o_cnt !== '0) begin n_err++; $display("FAIL en_cnt: got %0d want 0", bus.o_cnt); end
        n_cmp++; if (bus.o_period !== 1'b0) begin n_err++; $display("FAIL en_period: got %b want 0", bus.o_period); end
        repeat (3) step();
        bus.i_en = 1;
        for (int i = 0; i < 12; i++) begin
            step();
            n_cmp++;
            if (bus.o_pwm !== m_pwm || bus.o_period !== m_period || bus.o_cnt !== m_cnt) begin
                n_err++;
                $display("FAIL en_model cyc %0d: got pwm=%b per=%b cnt=%0d want pwm=%b per=%b cnt=%0d",
                         i, bus.o_pwm, bus.o_period, bus.o_cnt, m_pwm, m_period, m_cnt);
            end
        end
        for (int i = 0; i < 10 && bus.o_cnt != 3; i++) step();
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (bus.o_pwm !== '0) begin n_err++; $display("FAIL arst_pwm: got %b want 0", bus.o_pwm); end
        n_cmp++; if (bus.o_period !== 1'b0) begin n_err++; $display("FAIL arst_period: got %b want 0", bus.o_period); end
        n_cmp++; if (bus.o_cnt !== '0) begin n_err++; $display("FAIL arst_cnt: got %0d want 0", bus.o_cnt); end
        model_reset();
        #1 rst_n = 1'b1;
        set_cfg(0, 4, 2, 2, 2, 2, '0);
        pulse_upd();
        for (int i = 0; i < 12; i++) begin
            step();
            n_cmp++;
            if (bus.o_pwm !== m_pwm || bus.o_period !== m_period || bus.o_cnt !== m_cnt) begin
                n_err++;
                $display("FAIL arst_restart cyc %0d: got pwm=%b per=%b cnt=%0d want pwm=%b per=%b cnt=%0d",
                         i, bus.o_pwm, bus.o_period, bus.o_cnt, m_pwm, m_period, m_cnt);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            bus.i_en  = ($urandom_range(0, 15) != 0);
            bus.i_upd = ($urandom_range(0, 7) == 0);
            set_cfg(1'($urandom_range(0, 1)), $urandom_range(0, 12),
                    $urandom_range(0, 14), $urandom_range(0, 14),
                    $urandom_range(0, 14), $urandom_range(0, 14), NCH'($urandom));
            step();
            n_cmp++;
            if (bus.o_pwm !== m_pwm || bus.o_period !== m_period || bus.o_cnt !== m_cnt) begin
                n_err++;
                $display("FAIL random cyc %0d: got pwm=%b per=%b cnt=%0d want pwm=%b per=%b cnt=%0d",
                         i, bus.o_pwm, bus.o_period, bus.o_cnt, m_pwm, m_period, m_cnt);
            end
        end
        bus.i_upd = 1'b0;
    endtask

    initial begin
        test_reset();
        test_edge();
        test_centre();
        test_shadow();
        test_limits();
        test_multi();
        test_enable();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
